// File: rtl/system_reset_if.sv
// Reset-controller signal bundle: lock status and soft request in, staged resets and status out.
interface system_reset_if;
   logic       locked;
   logic       soft_rst_req;
   logic       bus_reset_;
   logic       cpu_reset_;
   logic [1:0] rst_cause;
   logic       ready;

   modport master (
      output locked,
      output soft_rst_req,
      input  bus_reset_,
      input  cpu_reset_,
      input  rst_cause,
      input  ready
   );

   modport slave (
      input  locked,
      input  soft_rst_req,
      output bus_reset_,
      output cpu_reset_,
      output rst_cause,
      output ready
   );
endinterface

// File: rtl/system_reset.sv
// Staged reset sequencer: filtered lock -> hold -> bus release -> gap -> cpu release.
// All outputs are registered; no backpressure, soft requests outside S_RUN are dropped.
module system_reset #(
   parameter int SYNC_STAGES = 2,
   parameter int LOCK_FILTER = 4,
   parameter int HOLD_CYCLES = 16,
   parameter int STAGE_GAP   = 8
) (
   input  logic          clk,
   input  logic          reset_,
   system_reset_if.slave rs
);
   localparam int CNT_MAX = (LOCK_FILTER > HOLD_CYCLES)
                          ? ((LOCK_FILTER > STAGE_GAP) ? LOCK_FILTER : STAGE_GAP)
                          : ((HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP);
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {
      S_RESET,
      S_WAIT_LOCK,
      S_HOLD,
      S_STAGE,
      S_RUN
   } state_t;

   logic [SYNC_STAGES-1:0] rst_chain;
   logic [SYNC_STAGES-1:0] lock_chain;
   logic                   rst_sync;
   logic                   locked_sync;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [1:0]         cause, cause_nxt;
   logic               bus_q, cpu_q, ready_q;

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         rst_chain  <= '0;
         lock_chain <= '0;
      end else begin
         rst_chain  <= {rst_chain[SYNC_STAGES-2:0], 1'b1};
         lock_chain <= {lock_chain[SYNC_STAGES-2:0], rs.locked};
      end
   end

   assign rst_sync    = rst_chain[SYNC_STAGES-1];
   assign locked_sync = lock_chain[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         state <= S_RESET;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Lock loss is tested before the soft request so it wins a same-cycle collision.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      cause_nxt = cause;
      case (state)
         S_RESET: begin
            if (rst_sync) begin
               state_nxt = S_WAIT_LOCK;
               cnt_nxt   = '0;
            end
         end
         S_WAIT_LOCK: begin
            if (!locked_sync) begin
               cnt_nxt = '0;
            end else if (cnt == CNT_W'(LOCK_FILTER - 1)) begin
               state_nxt = S_HOLD;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         S_HOLD, S_STAGE: begin
            if (!locked_sync) begin
               state_nxt = S_WAIT_LOCK;
               cnt_nxt   = '0;
               cause_nxt = 2'b10;
            end else if (state == S_HOLD && cnt == CNT_W'(HOLD_CYCLES - 1)) begin
               state_nxt = S_STAGE;
               cnt_nxt   = '0;
            end else if (state == S_STAGE && cnt == CNT_W'(STAGE_GAP - 1)) begin
               state_nxt = S_RUN;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         S_RUN: begin
            if (!locked_sync) begin
               state_nxt = S_WAIT_LOCK;
               cnt_nxt   = '0;
               cause_nxt = 2'b10;
            end else if (rs.soft_rst_req) begin
               state_nxt = S_HOLD;
               cnt_nxt   = '0;
               cause_nxt = 2'b11;
            end
         end
         default: begin
            state_nxt = S_RESET;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Outputs are decoded from the next state so they change on the same edge as the FSM.
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         bus_q   <= 1'b0;
         cpu_q   <= 1'b0;
         ready_q <= 1'b0;
         cause   <= 2'b01;
      end else begin
         bus_q   <= (state_nxt == S_STAGE) || (state_nxt == S_RUN);
         cpu_q   <= (state_nxt == S_RUN);
         ready_q <= (state_nxt == S_RUN);
         cause   <= cause_nxt;
      end
   end

   assign rs.bus_reset_ = bus_q;
   assign rs.cpu_reset_ = cpu_q;
   assign rs.ready      = ready_q;
   assign rs.rst_cause  = cause;
endmodule

// File: tb/tb_system_reset.sv
// Randomized bench for system_reset against a timeline-based reference model.
module tb_system_reset;
   localparam int SS = 2;
   localparam int LF = 4;
   localparam int HC = 16;
   localparam int SG = 8;

   logic clk = 1'b0;
   logic reset_;
   always #5 clk = ~clk;

   system_reset_if rif ();

   system_reset #(
      .SYNC_STAGES (SS),
      .LOCK_FILTER (LF),
      .HOLD_CYCLES (HC),
      .STAGE_GAP   (SG)
   ) dut (
      .clk    (clk),
      .reset_ (reset_),
      .rs     (rif.slave)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   // Model: released edge count, consecutive-good-lock count, and time since hold start.
   int m_rel, m_good, m_t, m_cause;
   bit m_started, m_filt, m_ls, m_rsync;
   bit lq[$];

   always @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         m_rel = 0; m_good = 0; m_t = 0; m_cause = 1;
         m_started = 0; m_filt = 1;
         lq.delete();
      end else begin
         m_ls    = (lq.size() >= SS) ? lq[SS-1] : 1'b0;
         m_rsync = (m_rel >= SS);
         lq.push_front(rif.locked);
         if (lq.size() > SS) void'(lq.pop_back());
         if (m_rel < 1000) m_rel++;
         if (!m_started) begin
            if (m_rsync) begin m_started = 1; m_filt = 1; m_good = 0; end
         end else if (m_filt) begin
            if (m_ls) begin
               m_good++;
               if (m_good == LF) begin m_filt = 0; m_t = 0; end
            end else m_good = 0;
         end else if (!m_ls) begin
            m_filt = 1; m_good = 0; m_cause = 2;
         end else if (rif.soft_rst_req && m_t >= HC + SG) begin
            m_t = 0; m_cause = 3;
         end else if (m_t < HC + SG) m_t++;
      end
   end

   task automatic step();
      bit eb, ec;
      @(negedge clk);
      eb = m_started && !m_filt && (m_t >= HC);
      ec = m_started && !m_filt && (m_t >= HC + SG);
      chk("bus_reset_", rif.bus_reset_, eb);
      chk("cpu_reset_", rif.cpu_reset_, ec);
      chk("ready",      rif.ready,      ec);
      chk("rst_cause",  rif.rst_cause,  m_cause);
      chk("cpu_le_bus", rif.cpu_reset_ & ~rif.bus_reset_, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int drop_left;
      rif.locked = 1'b1;
      rif.soft_rst_req = 1'b0;
      reset_ = 1'b1;
      #1 reset_ = 1'b0;
      repeat (3) step();
      chk("rst_bus", rif.bus_reset_, 0);
      chk("rst_cause0", rif.rst_cause, 1);

      // Power-on with lock held.
      reset_ = 1'b1;
      n = 0;
      do begin step(); n++; end while (rif.bus_reset_ !== 1'b1 && n < 100);
      chk("po_bus_rise", n, SS + 1 + LF + HC);
      n = 0;
      do begin step(); n++; end while (rif.cpu_reset_ !== 1'b1 && n < 100);
      chk("po_cpu_gap", n, SG);
      chk("po_ready", rif.ready, 1);
      chk("po_cause", rif.rst_cause, 1);

      // Soft reset from S_RUN.
      rif.soft_rst_req = 1'b1;
      step();
      rif.soft_rst_req = 1'b0;
      chk("soft_bus0", rif.bus_reset_, 0);
      chk("soft_cause", rif.rst_cause, 3);
      n = 0;
      do begin step(); n++; end while (rif.bus_reset_ !== 1'b1 && n < 100);
      chk("soft_bus_rise", n, HC);
      n = 0;
      do begin step(); n++; end while (rif.cpu_reset_ !== 1'b1 && n < 100);
      chk("soft_cpu_gap", n, SG);

      // Lock loss and soft request reach the FSM on the same edge.
      rif.locked = 1'b0;
      repeat (SS) step();
      rif.soft_rst_req = 1'b1;
      step();
      rif.soft_rst_req = 1'b0;
      chk("coll_cause", rif.rst_cause, 2);
      chk("coll_bus0", rif.bus_reset_, 0);

      // Glitch in the lock filter: 3 good, 1 bad, then steady.
      repeat (4) step();
      rif.locked = 1'b1; repeat (3) step();
      rif.locked = 1'b0; step();
      rif.locked = 1'b1;
      n = 0;
      do begin step(); n++; end while (rif.bus_reset_ !== 1'b1 && n < 100);
      chk("glitch_bus_rise", n, SS + LF + HC);
      chk("glitch_cause", rif.rst_cause, 2);

      // Asynchronous reset in the middle of S_STAGE.
      n = 0;
      while (!(rif.bus_reset_ === 1'b1 && rif.cpu_reset_ === 1'b0) && n < 200) begin
         step(); n++;
      end
      chk("stage_reached", rif.bus_reset_, 1);
      @(posedge clk);
      #3 reset_ = 1'b0;
      #1;
      chk("async_bus", rif.bus_reset_, 0);
      chk("async_cpu", rif.cpu_reset_, 0);
      chk("async_ready", rif.ready, 0);
      chk("async_cause", rif.rst_cause, 1);
      step();
      reset_ = 1'b1;
      n = 0;
      do begin step(); n++; end while (rif.bus_reset_ !== 1'b1 && n < 100);
      chk("rerun_bus_rise", n, SS + 1 + LF + HC);

      // Random traffic.
      drop_left = 0;
      for (int i = 0; i < 4000; i++) begin
         step();
         rif.soft_rst_req = ($urandom_range(0, 14) == 0);
         if (drop_left > 0) begin
            rif.locked = 1'b0;
            drop_left--;
         end else begin
            rif.locked = 1'b1;
            if ($urandom_range(0, 79) == 0) drop_left = $urandom_range(1, 6);
         end
         if (reset_ == 1'b0) reset_ = 1'b1;
         else if ($urandom_range(0, 599) == 0) reset_ = 1'b0;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
